// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings, FSM states, error codes and size helper for mem_access_ctrl
package mem_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] EC_SIZE = 2'b00;
  localparam logic [1:0] EC_ALIGN = 2'b01;
  localparam logic [1:0] EC_RANGE = 2'b10;
  localparam logic [1:0] EC_TIMEOUT = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SETUP, S_ACCESS, S_RELEASE, S_DONE, S_FAULT
  } state_t;
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_extend.sv
// mem_extend: low-lane select with sign/zero extension
//   ms   [2:0]  : [1:0] size, [2] sign-extend (ignored for word)
//   dout [31:0] : raw data, low lanes used
//   res  [31:0] : extended result
module mem_extend
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  ms,
  input  logic [31:0] dout,
  output logic [31:0] res
);
  always_comb
    res = ms[1:0] == SZ_BYTE ? {{24{ms[2] & dout[7]}}, dout[7:0]} :
          ms[1:0] == SZ_HALF ? {{16{ms[2] & dout[15]}}, dout[15:0]} : dout;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request load/store controller driving a MOV/MOC RAM
//   CLK, RST_N              : clock, async active-low reset
//   REQ, RW, MS, ADDR, WDATA: request (RW=1 read, MS[1:0] size, MS[2] signed load)
//   READY, DONE, ERR        : idle flag, completion pulse, abort pulse
//   ERR_CODE, RDATA         : abort reason, extended load result
//   MEM_*                   : RAM handshake and data (MOV out, MOC in)
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_LIMIT     = 256,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        RW,
  input  logic [2:0]  MS,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic [31:0] RDATA,
  output logic        MEM_MOV,
  output logic        MEM_RW,
  output logic [2:0]  MEM_MS,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_DIN,
  input  logic        MEM_MOC,
  input  logic [31:0] MEM_DOUT
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, nxt;
  logic rw_q;
  logic [2:0] ms_q;
  logic [31:0] addr_q, wdata_q, ext, din_mask;
  logic [1:0] code_q, fcode;
  logic [CW-1:0] cnt;
  logic fault, misaligned, out_of_range, tmo;
  mem_extend u_ext (.ms(ms_q), .dout(MEM_DOUT), .res(ext));
  // store data reuses the extender as a zero-extending mask
  mem_extend u_mask (.ms({1'b0, ms_q[1:0]}), .dout(wdata_q), .res(din_mask));
  always_comb begin
    misaligned = (ms_q[1:0] == SZ_HALF && addr_q[0]) || (ms_q[1:0] == SZ_WORD && addr_q[1:0] != 2'b00);
    out_of_range = {1'b0, addr_q} + 33'(size_bytes(ms_q[1:0])) > 33'(ADDR_LIMIT);
    fault = ms_q[1:0] == 2'b11 || misaligned || out_of_range;
    fcode = ms_q[1:0] == 2'b11 ? EC_SIZE : misaligned ? EC_ALIGN : EC_RANGE;
    // cnt counts completed cycles in the current state, so this fires on the last allowed one
    tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
    nxt = state;
    case (state)
      S_IDLE:    nxt = REQ ? S_CHECK : S_IDLE;
      S_CHECK:   nxt = fault ? S_FAULT : S_SETUP;
      S_SETUP:   nxt = S_ACCESS;
      S_ACCESS:  nxt = MEM_MOC ? S_RELEASE : tmo ? S_FAULT : S_ACCESS;
      S_RELEASE: nxt = !MEM_MOC ? S_DONE : tmo ? S_FAULT : S_RELEASE;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= S_IDLE;
      READY <= 1'b1;
      DONE <= 1'b0;
      ERR <= 1'b0;
      ERR_CODE <= EC_SIZE;
      RDATA <= '0;
      MEM_MOV <= 1'b0;
      MEM_RW <= 1'b1;
      MEM_MS <= '0;
      MEM_ADDR <= '0;
      MEM_DIN <= '0;
      rw_q <= 1'b1;
      ms_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      code_q <= EC_SIZE;
      cnt <= '0;
    end else begin
      state <= nxt;
      READY <= nxt == S_IDLE;
      DONE <= nxt == S_DONE;
      MEM_MOV <= nxt == S_ACCESS;
      // ERR is raised as FAULT is left, giving the two-cycle abort latency
      ERR <= state == S_FAULT;
      if (state == S_FAULT) ERR_CODE <= code_q;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      if (state == S_IDLE && REQ) begin
        rw_q <= RW;
        ms_q <= MS;
        addr_q <= ADDR;
        wdata_q <= WDATA;
      end
      if (state == S_CHECK) code_q <= fcode;
      if ((state == S_ACCESS || state == S_RELEASE) && nxt == S_FAULT) code_q <= EC_TIMEOUT;
      if (state == S_CHECK && nxt == S_SETUP) begin
        MEM_ADDR <= addr_q;
        MEM_RW <= rw_q;
        MEM_MS <= {1'b0, ms_q[1:0]};
        MEM_DIN <= din_mask;
      end
      if (state == S_ACCESS && MEM_MOC && rw_q) RDATA <= ext;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side memory access controller sitting directly upstream of `ram256x8`. It accepts one load/store request at a time from the datapath, checks size, alignment and range, and drives the RAM's MOV/ReadWrite/MS/Address/DataIn inputs through a four-phase MOV/MOC handshake. On loads it captures the RAM's DataOut, applies sign or zero extension, and returns the result with a one-cycle DONE pulse. Faults and MOC timeouts are reported on ERR without leaving the RAM in a half-finished access.

## Interface
- `ADDR_LIMIT`, 256: first illegal byte address; access is out of range if `ADDR + size_bytes > ADDR_LIMIT`.
- `TIMEOUT_CYCLES`, 15: max cycles spent in ACCESS or RELEASE before timeout.

Clock and reset: one clock; reset is asynchronous and active-low.
- `CLK` in 1: system clock, rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `REQ` in 1: request valid, sampled only when READY=1.
- `RW` in 1: 1 = read, 0 = write.
- `MS` in 3: [1:0] size (00 byte, 01 halfword, 10 word, 11 illegal); [2] signed load.
- `ADDR` in 32: byte address.
- `WDATA` in 32: store data, low bytes used.
- `READY` out 1: idle, can accept REQ.
- `DONE` out 1: one-cycle pulse, access completed.
- `ERR` out 1: one-cycle pulse, access aborted.
- `ERR_CODE` out 2: 00 illegal size, 01 misaligned, 10 out of range, 11 timeout; valid with ERR.
- `RDATA` out 32: extended load result, held until next load completes.
- `MEM_MOV` out 1: to RAM MOV.
- `MEM_RW` out 1: to RAM ReadWrite.
- `MEM_MS` out 3: to RAM MS_2_0; bit 2 always 0.
- `MEM_ADDR` out 32: to RAM Address.
- `MEM_DIN` out 32: to RAM DataIn.
- `MEM_MOC` in 1: from RAM MOC.
- `MEM_DOUT` in 32: from RAM DataOut.

## Operation
- States: IDLE, CHECK, SETUP, ACCESS, RELEASE, DONE, FAULT.
- IDLE: READY=1. On REQ=1, latch RW, MS, ADDR and WDATA, then go to CHECK.
- CHECK: faults are checked in priority order size > alignment > range:
  - size 11 is illegal;
  - a halfword needs ADDR[0]=0;
  - a word needs ADDR[1:0]=00.
  - Any fault goes to FAULT; otherwise go to SETUP.
- SETUP: drive MEM_ADDR, MEM_RW, MEM_MS={0,size} and MEM_DIN with MEM_MOV=0 for exactly one cycle, then go to ACCESS.
- ACCESS: MEM_MOV=1.
  - On MEM_MOC=1, capture the extended MEM_DOUT into RDATA if read, drop MEM_MOV and go to RELEASE.
- RELEASE: MEM_MOV=0, wait for MEM_MOC=0, then go to DONE.
- DONE: DONE=1 for one cycle, then go to IDLE.
- FAULT: ERR=1 with ERR_CODE for one cycle, then go to IDLE. RDATA is unchanged and the RAM is never touched (MEM_MOV stays 0).
- Timeout: the counter clears on entry to ACCESS and on entry to RELEASE. When it reaches TIMEOUT_CYCLES, go to FAULT with code 11 and MEM_MOV=0.
- Extension of the low lane of MEM_DOUT:
  - byte: bits [7:0];
  - halfword: bits [15:0];
  - word: all 32 bits, MS[2] ignored;
  - MS[2]=1 sign-extends, 0 zero-extends.
- Store data: MEM_DIN is WDATA masked to the access size, upper bits zero.
- Writes leave RDATA unchanged.
- REQ is ignored outside IDLE; there is no queueing.

## Timing
- Reset: the asynchronous assertion forces IDLE. Outputs at reset:
  - READY=1;
  - DONE=0, ERR=0, ERR_CODE=00;
  - RDATA=0;
  - MEM_MOV=0, MEM_RW=1, MEM_MS=000, MEM_ADDR=0, MEM_DIN=0.
- Reset mid-access drops MEM_MOV immediately, with no wait for MOC.
- All outputs are registered.
- REQ is sampled at edge t0. CHECK occupies t0..t0+1, SETUP from t0+1 and ACCESS from t0+2.
- With a RAM asserting MOC one cycle after MOV and dropping it one cycle after MOV falls:
  - DONE is high during [t0+5, t0+6);
  - READY returns at t0+6.
- Fault latency: ERR is high during [t0+2, t0+3).
- MEM_MOC already high on entry to ACCESS is accepted on the first ACCESS edge.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the MS size encodings (BYTE, HALF, WORD);
  - the state enum;
  - the ERR_CODE constants;
  - a size-in-bytes helper function.
- Sub-module `mem_extend`: combinational lane select plus sign/zero extension. Inputs MS and DOUT, output 32-bit result. It is reused for store-data masking with the sign bit forced 0.

## Test plan
- Signed byte load: RAM byte at 5 = 8'h85, MS=100 -> RDATA=32'hFFFFFF85, DONE pulse at t0+5, MEM_MS=000.
- Unsigned halfword load: bytes at 14..15 give 16'h8001, MS=001 -> RDATA=32'h00008001.
- Word store: ADDR=12, WDATA=32'hC0000001, MS=010 -> RAM sees MOV with RW=0 and DIN=32'hC0000001; RDATA unchanged.
- Misaligned word: ADDR=13, MS=010 -> ERR_CODE=01, ERR pulse at t0+2, MEM_MOV never asserted.
- Range and size checks:
  - ADDR=255 halfword -> ERR_CODE=01 (alignment wins);
  - ADDR=254 word -> ERR_CODE=01;
  - ADDR=256 byte -> ERR_CODE=10;
  - MS=011 -> ERR_CODE=00.
- Timeout and reset:
  - MOC held low -> ERR_CODE=11 after 15 ACCESS cycles, MEM_MOV=0.
  - RST_N pulsed mid-ACCESS -> MEM_MOV=0 immediately, READY=1.
